block_lock: RTL and testbench

//  64b/66b sync-header block-lock FSM for one 40GbE PCS lane (Clause 82/49 style).

---
 rtl/block_lock_if.sv | 24 ++
 rtl/block_lock.sv | 147 ++++++++++++++
 tb/tb_block_lock.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/block_lock_if.sv
// Lane-side bundle for the 64b/66b block-lock stage: gearbox blocks in, aligned blocks out.
// Strobe semantics: there is no ready; a block transfers on every clk edge with rx_valid=1 (in) or out_valid=1 (out).
interface block_lock_if;
  logic        rx_valid;
  logic [1:0]  rx_header;
  logic [63:0] rx_data;
  logic        slip;
  logic        block_lock;
  logic        out_valid;
  logic [1:0]  out_header;
  logic [63:0] out_data;
  logic        out_hdr_err;
  logic [1:0]  state;

  modport master (
    output rx_valid, rx_header, rx_data,
    input  slip, block_lock, out_valid, out_header, out_data, out_hdr_err, state
  );

  modport slave (
    input  rx_valid, rx_header, rx_data,
    output slip, block_lock, out_valid, out_header, out_data, out_hdr_err, state
  );
endinterface

// File: rtl/block_lock.sv
// 64b/66b sync-header block-lock FSM for one PCS lane: hunts for alignment via gearbox slips,
// monitors invalid headers while locked and forwards aligned (still scrambled) blocks.
module block_lock #(
  parameter int LOCK_CNT  = 64,
  parameter int WINDOW    = 64,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 2
) (
  input  logic         clk,
  input  logic         reset,
  block_lock_if.slave  lane
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(LOCK_CNT, WINDOW), max2(BAD_MAX, SLIP_WAIT));
  localparam int CW   = $clog2(MAXP) + 1;

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_LOCKED    = 2'd1,
    ST_SLIP_WAIT = 2'd2
  } state_t;

  state_t      state;
  logic [CW-1:0] hunt_cnt;
  logic [CW-1:0] win_cnt;
  logic [CW-1:0] bad_cnt;
  logic [CW-1:0] wait_cnt;

  logic        slip_q;
  logic        lock_q;
  logic        out_valid_q;
  logic [1:0]  out_header_q;
  logic [63:0] out_data_q;
  logic        out_hdr_err_q;

  logic hdr_ok;
  assign hdr_ok = lane.rx_header[0] ^ lane.rx_header[1];

  assign lane.slip        = slip_q;
  assign lane.block_lock  = lock_q;
  assign lane.out_valid   = out_valid_q;
  assign lane.out_header  = out_header_q;
  assign lane.out_data    = out_data_q;
  assign lane.out_hdr_err = out_hdr_err_q;
  assign lane.state       = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_HUNT;
      hunt_cnt      <= '0;
      win_cnt       <= '0;
      bad_cnt       <= '0;
      wait_cnt      <= '0;
      slip_q        <= 1'b0;
      lock_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_header_q  <= '0;
      out_data_q    <= '0;
      out_hdr_err_q <= 1'b0;
    end else begin
      slip_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_hdr_err_q <= 1'b0;
      if (lane.rx_valid) begin
        case (state)
          ST_HUNT: begin
            if (hdr_ok) begin
              if (hunt_cnt == CW'(LOCK_CNT - 1)) begin
                // The block completing lock is itself forwarded.
                state         <= ST_LOCKED;
                lock_q        <= 1'b1;
                hunt_cnt      <= '0;
                win_cnt       <= '0;
                bad_cnt       <= '0;
                wait_cnt      <= '0;
                out_valid_q   <= 1'b1;
                out_header_q  <= lane.rx_header;
                out_data_q    <= lane.rx_data;
                out_hdr_err_q <= 1'b0;
              end else begin
                hunt_cnt <= hunt_cnt + CW'(1);
              end
            end else begin
              state    <= ST_SLIP_WAIT;
              slip_q   <= 1'b1;
              hunt_cnt <= '0;
              wait_cnt <= '0;
            end
          end

          ST_LOCKED: begin
            if (!hdr_ok && (bad_cnt == CW'(BAD_MAX - 1))) begin
              // Loss takes priority over a window rollover on the same block.
              state    <= ST_SLIP_WAIT;
              slip_q   <= 1'b1;
              lock_q   <= 1'b0;
              hunt_cnt <= '0;
              win_cnt  <= '0;
              bad_cnt  <= '0;
              wait_cnt <= '0;
            end else begin
              out_valid_q   <= 1'b1;
              out_header_q  <= lane.rx_header;
              out_data_q    <= lane.rx_data;
              out_hdr_err_q <= !hdr_ok;
              if (win_cnt == CW'(WINDOW - 1)) begin
                win_cnt <= '0;
                bad_cnt <= '0;
              end else begin
                win_cnt <= win_cnt + CW'(1);
                if (!hdr_ok) begin
                  bad_cnt <= bad_cnt + CW'(1);
                end
              end
            end
          end

          ST_SLIP_WAIT: begin
            // Blocks right after a slip may straddle the old alignment; skip them untested.
            if (wait_cnt == CW'(SLIP_WAIT - 1)) begin
              state    <= ST_HUNT;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end

          default: begin
            state    <= ST_HUNT;
            hunt_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
            wait_cnt <= '0;
            lock_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  slip_single_cycle: assert property (@(posedge clk) disable iff (reset) slip_q |=> !slip_q);

endmodule

// File: tb/tb_block_lock.sv
// Randomized bench for block_lock against a counting reference model of the lock rules.
module tb_block_lock;
  localparam int LOCK_N = 64;
  localparam int WIN_N  = 64;
  localparam int BAD_N  = 16;
  localparam int WAIT_N = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  block_lock_if bif ();

  block_lock dut (
    .clk   (clk),
    .reset (reset),
    .lane  (bif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [66:0] exp_q[$];

  // reference model: a run of good headers, position and bad count in the current window,
  // and how many blocks remain to skip after a slip
  bit          m_locked;
  int          m_run, m_pos, m_bad, m_skip;
  logic [1:0]  m_last_hdr;
  logic [63:0] m_last_data;
  bit          gaps_on;

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_locked = 0; m_run = 0; m_pos = 0; m_bad = 0; m_skip = 0;
    m_last_hdr = '0; m_last_data = '0;
    exp_q.delete();
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
  endfunction

  // one clock: drive at negedge, update model, check #1 after the posedge
  task automatic cycle(input bit v, input logic [1:0] hdr);
    logic [63:0] d;
    logic [66:0] e;
    bit e_slip, e_fwd, ok;
    d = {$urandom, $urandom};
    e_slip = 0; e_fwd = 0;
    ok = (hdr == 2'b01) || (hdr == 2'b10);
    bif.rx_valid = v; bif.rx_header = hdr; bif.rx_data = d;
    if (v) begin
      if (m_skip > 0) begin
        m_skip--;
      end else if (!m_locked) begin
        if (ok) begin
          m_run++;
          if (m_run == LOCK_N) begin
            m_locked = 1; m_run = 0; m_pos = 0; m_bad = 0; e_fwd = 1;
          end
        end else begin
          m_run = 0; e_slip = 1; m_skip = WAIT_N;
        end
      end else begin
        m_pos++;
        if (!ok) m_bad++;
        if (m_bad == BAD_N) begin
          m_locked = 0; e_slip = 1; m_skip = WAIT_N; m_pos = 0; m_bad = 0;
        end else begin
          e_fwd = 1;
          if (m_pos == WIN_N) begin m_pos = 0; m_bad = 0; end
        end
      end
    end
    if (e_fwd) begin
      exp_q.push_back({~ok, hdr, d});
      m_last_hdr = hdr; m_last_data = d;
    end
    @(posedge clk);
    #1;
    check("slip", 67'(bif.slip), 67'(e_slip));
    check("block_lock", 67'(bif.block_lock), 67'(m_locked));
    check("out_valid", 67'(bif.out_valid), 67'(e_fwd));
    if (bif.out_valid) begin
      check("sb_nonempty", 67'(exp_q.size() > 0), 67'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd_block", {bif.out_hdr_err, bif.out_header, bif.out_data}, e);
      end
    end else begin
      check("hold_hdr", 67'(bif.out_header), 67'(m_last_hdr));
      check("hold_data", 67'(bif.out_data), 67'(m_last_data));
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] hdr);
    int g;
    g = 0;
    if (gaps_on && ($urandom_range(0, 2) == 0)) g = $urandom_range(1, 5);
    for (int i = 0; i < g; i++) cycle(1'b0, ($urandom_range(0, 1) == 1) ? bad_hdr() : good_hdr());
    cycle(1'b1, hdr);
  endtask

  task automatic do_reset();
    bif.rx_valid = 1'b0;
    reset = 1'b1;
    #2;
    check("rst_slip", 67'(bif.slip), 67'(0));
    check("rst_lock", 67'(bif.block_lock), 67'(0));
    check("rst_out_valid", 67'(bif.out_valid), 67'(0));
    check("rst_hdr_err", 67'(bif.out_hdr_err), 67'(0));
    check("rst_out_header", 67'(bif.out_header), 67'(0));
    check("rst_out_data", 67'(bif.out_data), 67'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic seq_hunt_slip();
    do_reset();
    repeat (10) send(good_hdr());
    send(2'b00);
    send(2'b11);
    send(2'b11);
    repeat (LOCK_N) send(good_hdr());
    check("t2_locked", 67'(bif.block_lock), 67'(1));
  endtask

  task automatic seq_window_loss();
    // enters from a fresh lock: 15 bad spread over the window, then the 16th
    for (int p = 0; p < 60; p++) send((p % 4 == 0) ? bad_hdr() : good_hdr());
    check("t3_held", 67'(bif.block_lock), 67'(1));
    send(bad_hdr());
    check("t3_lost", 67'(bif.block_lock), 67'(0));
  endtask

  initial begin
    bif.rx_valid = 1'b0; bif.rx_header = '0; bif.rx_data = '0;
    gaps_on = 0;
    model_reset();
    @(negedge clk);

    // lock after exactly 64 good headers
    do_reset();
    repeat (LOCK_N - 1) send(good_hdr());
    check("t1_not_yet", 67'(bif.block_lock), 67'(0));
    send(2'b01);
    check("t1_locked", 67'(bif.block_lock), 67'(1));
    check("t1_first_valid", 67'(bif.out_valid), 67'(1));

    seq_hunt_slip();
    seq_window_loss();

    // 15 bad in two consecutive windows, then loss on the last block of a window
    repeat (WAIT_N + LOCK_N) send(good_hdr());
    for (int w = 0; w < 2; w++)
      for (int p = 0; p < WIN_N; p++) send((p < 15) ? bad_hdr() : good_hdr());
    check("t4_held", 67'(bif.block_lock), 67'(1));
    for (int p = 0; p < WIN_N - 1; p++) send((p >= 48) ? bad_hdr() : good_hdr());
    check("t4_held_63", 67'(bif.block_lock), 67'(1));
    send(bad_hdr());
    check("t4_lost", 67'(bif.block_lock), 67'(0));

    // same scenarios with idle gaps
    gaps_on = 1;
    seq_hunt_slip();
    seq_window_loss();
    gaps_on = 0;

    // reset mid-window and mid-slip-wait
    do_reset();
    repeat (LOCK_N) send(good_hdr());
    repeat (7) begin send(bad_hdr()); send(good_hdr()); end
    do_reset();
    repeat (LOCK_N - 1) send(good_hdr());
    check("t6_relock_pending", 67'(bif.block_lock), 67'(0));
    send(good_hdr());
    check("t6_relocked", 67'(bif.block_lock), 67'(1));
    do_reset();
    repeat (5) send(good_hdr());
    send(bad_hdr());
    send(good_hdr());
    do_reset();
    repeat (LOCK_N) send(good_hdr());
    check("t6_lock_after_wait_reset", 67'(bif.block_lock), 67'(1));

    // random soak
    for (int r = 0; r < 40; r++) begin
      int pct;
      if ($urandom_range(0, 4) == 0) do_reset();
      case ($urandom_range(0, 3))
        0: pct = 0;
        1: pct = 2;
        2: pct = 10;
        default: pct = 30;
      endcase
      gaps_on = ($urandom_range(0, 1) == 1);
      repeat (100) send(($urandom_range(0, 99) < pct) ? bad_hdr() : good_hdr());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
